dir_req_arbiter: RTL
====================

Name: dir_req_arbiter

Overview:
- Two-port request arbiter between the two cache controllers (cc1, cc2) and the directory.
- Serialises block requests (read-shared / exclusive) onto the directory's single request channel.
- Round-robin priority; holds each grant until the directory signals completion, then pulses an ack back to the winner.
- Replaces direct cache-to-directory request wiring; uses the Arbiter_status state set.

Parameters:
- ADDR_W, 1, block address width (matches address_size+1).
- TIMEOUT_CYC, 15, WAIT cycles before abort; used only with ARB_TIMEOUT_EN; must be >= 2.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cache_req1  in  2  Cache_reqstatus from cc1
- blk_add1  in  ADDR_W  block address from cc1
- back_data1  in  1  write-back data from cc1
- cache_req2  in  2  Cache_reqstatus from cc2
- blk_add2  in  ADDR_W  block address from cc2
- back_data2  in  1  write-back data from cc2
- arb_ack1  out  1  one-cycle completion pulse to cc1
- arb_ack2  out  1  one-cycle completion pulse to cc2
- dir_valid  out  1  one-cycle request strobe to the directory
- dir_req  out  2  latched Cache_reqstatus of the granted cache
- dir_add  out  ADDR_W  latched block address
- dir_data  out  1  latched back_data
- dir_src  out  1  granted cache: 0 = cc1, 1 = cc2
- dir_done  in  1  directory completion, one-cycle pulse
- arb_timeout  out  1  abort pulse; constant 0 when the feature is off
- arb_state  out  3  current Arbiter_status, for debug

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - rst_n is asynchronous and active-low; it immediately forces state ONE and drives every output and every latched field to 0.
  - Reset mid-transaction drops the transaction silently. No ack is issued.
- Pending request: cache_reqN is blk_rreq or blk_excl. The values ok and noop are idle.
- Requester contract:
  - A cache holds cache_reqN, blk_addN and back_dataN stable from assertion until its ack.
  - It drops the request in the ack cycle.
  - The arbiter masks requester N's pending bit while arb_ackN=1.
- State encoding, shared with the package: ONE=0, ONEWAIT=1, TWO=2, TWOWAIT=3, ONESERVE=4, TWOSERVE=5.
- ONE (idle, cc1 has priority):
  - pend1 -> ONESERVE.
  - else pend2 -> TWOSERVE.
  - else stay.
- TWO: mirror image of ONE, with cc2 having priority.
- Grant:
  - On the transition into xSERVE, latch req/add/data of the winner into dir_req/dir_add/dir_data, and set dir_src.
- xSERVE:
  - dir_valid=1 for exactly this cycle.
  - Unconditional move to xWAIT.
  - dir_done in this cycle is ignored. The directory latency is >= 1 cycle after dir_valid.
- xWAIT:
  - Latched outputs are held and dir_valid=0.
  - On dir_done: arb_ackN=1 in the next cycle.
  - Next state is the opposite idle state: after ONEWAIT go to TWO, after TWOWAIT go to ONE.
- Latency:
  - Request seen in idle at edge t -> dir_valid at t+1.
  - dir_done at edge k -> ack at k+1.
  - Minimum request-to-ack is 3 cycles.
- Simultaneous requests: the priority holder wins. The loser is served next, with no starvation.
- A request raised in the same cycle as the other cache's ack is accepted normally from the idle state.
- Latched fields persist after completion until the next grant.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Enabled:
  - A down-counter loads TIMEOUT_CYC on entering xWAIT and decrements each WAIT cycle.
  - On reaching 0 without dir_done: arb_timeout=1 and arb_ackN=1 together for one cycle.
  - The state then goes to the opposite idle state, the same as a normal completion.
  - dir_done arriving in the same cycle as expiry wins: normal ack, no timeout.
- Disabled: xWAIT waits indefinitely, and arb_timeout is tied 0.

Decomposition:
- Package coherence_pkg holds:
  - Cache_reqstatus (ok=0, blk_rreq=1, blk_excl=2, noop=3)
  - Arbiter_status, with the encodings above
  - Block_status
  - ADDR_W default
- Sub-module arb_watchdog, the counter plus expiry flag. Instantiated only under ARB_TIMEOUT_EN.

Test Plan:
1. Reset, then cc1 blk_rreq addr 1 at cycle 2, dir_done at cycle 5 -> dir_valid at cycle 3 with dir_req=1, dir_add=1, dir_src=0; arb_ack1 at cycle 6; state ends in TWO.
2. Both caches request (cc1 blk_excl addr 0, cc2 blk_rreq addr 1) from state ONE -> cc1 served first, then cc2 granted straight from TWO; no dir_valid while WAIT.
3. cc1 re-requests back-to-back with cc2 continuously pending -> grants alternate cc1, cc2, cc1; no second consecutive cc1 grant.
4. dir_done asserted during ONESERVE only -> ignored; state stays ONEWAIT; no ack.
5. rst_n low during TWOWAIT -> all outputs 0 immediately; state ONE; no arb_ack2 after release.
6. ARB_TIMEOUT_EN, TIMEOUT_CYC=4, no dir_done -> arb_timeout and arb_ack1 pulse 4 cycles after entering ONEWAIT. With dir_done on the expiry cycle -> ack only, arb_timeout stays 0.

Source files
------------

// File: rtl/coherence_pkg.sv
// Shared coherence types: cache request codes, arbiter states, block states.
// Read by dir_req_arbiter and the bench; ARB_TIMEOUT_EN lives in the arbiter.
package coherence_pkg;

    localparam int DEF_ADDR_W = 1;

    typedef enum logic [1:0] {
        ok       = 2'd0,
        blk_rreq = 2'd1,
        blk_excl = 2'd2,
        noop     = 2'd3
    } cache_reqstatus_t;

    typedef enum logic [2:0] {
        ONE      = 3'd0,
        ONEWAIT  = 3'd1,
        TWO      = 3'd2,
        TWOWAIT  = 3'd3,
        ONESERVE = 3'd4,
        TWOSERVE = 3'd5
    } arbiter_status_t;

    typedef enum logic [1:0] {
        blk_invalid   = 2'd0,
        blk_shared    = 2'd1,
        blk_exclusive = 2'd2
    } block_status_t;

    function automatic logic is_pending(input logic [1:0] r);
        return (r == blk_rreq) || (r == blk_excl);
    endfunction

endpackage

// File: rtl/arb_watchdog.sv
// Wait-phase down-counter; flags the last cycle before the count hits 0.
// Only instantiated when ARB_TIMEOUT_EN is defined.
module arb_watchdog #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic run,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CW'(TIMEOUT_CYC);
        end else if (run && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // This edge takes the count to zero.
    assign expire = run && (cnt == CW'(1));

endmodule

// File: rtl/dir_req_arbiter.sv
// Round-robin arbiter putting cc1/cc2 block requests onto the directory.
// Optional wait-phase abort is enabled by defining ARB_TIMEOUT_EN.
module dir_req_arbiter
    import coherence_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        cache_req1,
    input  logic [ADDR_W-1:0] blk_add1,
    input  logic              back_data1,
    input  logic [1:0]        cache_req2,
    input  logic [ADDR_W-1:0] blk_add2,
    input  logic              back_data2,
    output logic              arb_ack1,
    output logic              arb_ack2,
    output logic              dir_valid,
    output logic [1:0]        dir_req,
    output logic [ADDR_W-1:0] dir_add,
    output logic              dir_data,
    output logic              dir_src,
    input  logic              dir_done,
    output logic              arb_timeout,
    output logic [2:0]        arb_state
);

    if (TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("TIMEOUT_CYC must be at least 2");
    end

    arbiter_status_t state, state_nx;
    logic pend1, pend2;
    logic serving, waiting;
    logic expire;

    // An acked requester is still dropping its request this cycle.
    assign pend1 = is_pending(cache_req1) && !arb_ack1;
    assign pend2 = is_pending(cache_req2) && !arb_ack2;

    assign serving   = (state == ONESERVE) || (state == TWOSERVE);
    assign waiting   = (state == ONEWAIT) || (state == TWOWAIT);
    assign dir_valid = serving;
    assign arb_state = state;

    always_comb begin
        state_nx = state;
        unique case (state)
            ONE: begin
                if (pend1) begin
                    state_nx = ONESERVE;
                end else if (pend2) begin
                    state_nx = TWOSERVE;
                end
            end
            TWO: begin
                if (pend2) begin
                    state_nx = TWOSERVE;
                end else if (pend1) begin
                    state_nx = ONESERVE;
                end
            end
            ONESERVE: state_nx = ONEWAIT;
            TWOSERVE: state_nx = TWOWAIT;
            ONEWAIT: begin
                if (dir_done || expire) begin
                    state_nx = TWO;
                end
            end
            TWOWAIT: begin
                if (dir_done || expire) begin
                    state_nx = ONE;
                end
            end
            default: state_nx = ONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ONE;
            arb_ack1 <= 1'b0;
            arb_ack2 <= 1'b0;
            dir_req  <= '0;
            dir_add  <= '0;
            dir_data <= 1'b0;
            dir_src  <= 1'b0;
        end else begin
            state    <= state_nx;
            arb_ack1 <= (state == ONEWAIT) && (dir_done || expire);
            arb_ack2 <= (state == TWOWAIT) && (dir_done || expire);
            // SERVE is only reachable from idle, so this is the grant edge.
            if (state_nx == ONESERVE) begin
                dir_req  <= cache_req1;
                dir_add  <= blk_add1;
                dir_data <= back_data1;
                dir_src  <= 1'b0;
            end else if (state_nx == TWOSERVE) begin
                dir_req  <= cache_req2;
                dir_add  <= blk_add2;
                dir_data <= back_data2;
                dir_src  <= 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    arb_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .start (serving),
        .run   (waiting),
        .expire(expire)
    );

    // A completion on the expiry edge counts as a normal finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_timeout <= 1'b0;
        end else begin
            arb_timeout <= waiting && expire && !dir_done;
        end
    end
`else
    assign expire      = 1'b0;
    assign arb_timeout = 1'b0;
`endif

endmodule
